// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank
//  Purpose  : Parametrised configuration/status register bank. DEPTH words of
//             DATA_WIDTH bits, byte-strobed writes, one-cycle registered reads
//             with a valid strobe, out-of-range / busy error strobe, and a
//             hardware clear sequencer that runs after every reset.
//  Ports    : clk, rst                   - clock, synchronous active-high reset
//             wr_in, rd_in               - single-cycle write / read requests
//             addr_in, data_in, be_in    - word address, write data, byte enables
//             data_out, data_valid_out   - read data and its strobe
//             err_out                    - bad address or request while busy
//             busy_out                   - clear sequencer running
//             parity_err_out, par_flip_in- only with REG_BANK_PARITY_EN
//  Options  : `define REG_BANK_PARITY_EN adds one even-parity bit per stored
//             byte, a parity-mismatch flag on reads and a parity-inject input.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter int                    DEPTH      = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_in,
    input  logic                         rd_in,
    input  logic [$clog2(DEPTH)-1:0]     addr_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [DATA_WIDTH/8-1:0]      be_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid_out,
    output logic                         err_out,
    output logic                         busy_out
`ifdef REG_BANK_PARITY_EN
    ,
    output logic                         parity_err_out,
    input  logic                         par_flip_in
`endif
);

    localparam int                ADDR_W  = $clog2(DEPTH);
    localparam int                BE_W    = DATA_WIDTH / 8;
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);
    // One extra bit so non-power-of-two depths compare correctly.
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_clr_cnt;
    logic                  w_clearing;
    logic                  w_idle;
    logic                  w_addr_ok;
    logic                  w_clr_last;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [BE_W-1:0]       w_mem_be;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;

    assign w_clearing = (r_state == S_CLEAR);
    assign w_idle     = (r_state == S_IDLE);
    assign w_addr_ok  = ({1'b0, addr_in} < C_DEPTH);
    assign w_clr_last = (r_clr_cnt == C_LAST);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clearing) begin
                r_clr_cnt <= w_clr_last ? '0 : (r_clr_cnt + C_ONE);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clearing && w_clr_last) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Single write port shared by the clear sequencer and host writes.
    // While clearing, host writes are dropped entirely.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_addr  = addr_in;
        w_mem_wdata = data_in;
        w_mem_be    = '0;
        if (w_clearing) begin
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = INIT_VALUE;
            w_mem_be    = '1;
        end else if (wr_in && w_addr_ok) begin
            w_mem_be    = be_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef REG_BANK_PARITY_EN
    logic [BE_W-1:0] r_par [DEPTH];
    logic            w_flip;
    logic            w_par_mismatch;
    logic            r_perr;

    // Injected parity errors only apply to host writes, never to clearing.
    assign w_flip = w_clearing ? 1'b0 : par_flip_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_mem_be[i]) begin
                    r_par[w_mem_addr][i] <= (^w_mem_wdata[8*i +: 8]) ^ w_flip;
                end
            end
        end
    end

    always_comb begin
        w_par_mismatch = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            w_par_mismatch = w_par_mismatch |
                             (r_par[addr_in][i] != (^r_mem[addr_in][8*i +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_idle & rd_in & w_addr_ok & w_par_mismatch;
        end
    end

    assign parity_err_out = r_perr;
`endif

    // ------------------------------------------------------------------
    // Read response. The memory is sampled before this edge's write lands,
    // which gives read-before-write on a same-address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= rd_in;
            if (w_idle) begin
                r_err <= (rd_in | wr_in) & ~w_addr_ok;
                if (rd_in) begin
                    r_data <= w_addr_ok ? r_mem[addr_in] : '0;
                end
            end else begin
                r_err <= rd_in | wr_in;
                if (rd_in) begin
                    r_data <= '0;
                end
            end
        end
    end

    assign data_out       = r_data;
    assign data_valid_out = r_valid;
    assign err_out        = r_err;
    assign busy_out       = w_clearing;

endmodule
`default_nettype wire
